// File: rtl/rgb_sched_pkg.sv
// Shared types and default sizing for the RGB sequencer scheduler.
// Pure declarations, no timing or flow control.
package rgb_sched_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_MAX = 64;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_START = 3'd2,
        RUN        = 3'd3,
        DONE       = 3'd4
    } state_e;

endpackage

// File: rtl/rgb_rr_arbiter.sv
// Purpose: picks one one-hot winner from req; round-robin from ptr, or fixed lowest-index with RGB_SCHED_FIXED_PRIO_EN.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample winner.
module rgb_rr_arbiter
    import rgb_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

`ifdef RGB_SCHED_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin : fixed_arb
        logic found;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`else
    // First pass covers ptr..NUM_REQ-1; the second pass supplies the wrapped winner.
    always_comb begin : rr_arb
        logic found;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rgb_seq_sched.sv
// Purpose: shares one RGB sequencer among NUM_REQ requesters (arbitration mode set by RGB_SCHED_FIXED_PRIO_EN).
// Latency: req->grant 1 cycle, last colour low->done 1 cycle, done->next grant >=1 cycle.
// Backpressure: requests wait while busy; a watchdog ends stuck sequences with sticky timeout_err.
module rgb_seq_sched
    import rgb_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_MAX = DEF_TIMEOUT_MAX
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               seq_button,
    input  logic               seq_red,
    input  logic               seq_green,
    input  logic               seq_blue,
    output logic               busy,
    output logic               timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_MAX + 1);
    localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT_MAX - 1);

    state_e               state_q;
    state_e               state_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic [NUM_REQ-1:0]   done_d;
    logic                 button_d;
    logic                 busy_d;
    logic                 err_d;
    logic [WD_W-1:0]      wdog_q;
    logic [WD_W-1:0]      wdog_d;
    logic [NUM_REQ-1:0]   winner;
    logic [PTR_W-1:0]     arb_ptr;
    logic                 any_colour;
    logic                 wd_fire;

    assign any_colour = seq_red | seq_green | seq_blue;
    assign wd_fire    = (wdog_q == WD_FIRE);

`ifdef RGB_SCHED_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_idx;

    assign arb_ptr = rr_ptr_q;

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) owner_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (state_q == DONE) begin
            rr_ptr_q <= (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
        end
    end
`endif

    rgb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req    (req),
        .ptr    (arb_ptr),
        .winner (winner)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        err_d   = timeout_err;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = LAUNCH;
                    grant_d = winner;
                end
            end
            LAUNCH: begin
                // Colours are not sampled here: anything still high is left over from before.
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (wd_fire) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (any_colour) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wd_fire) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (!any_colour) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        button_d = (state_d == LAUNCH);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE) ? grant_d : '0;

        wdog_d = wdog_q;
        if (state_d == LAUNCH) begin
            wdog_d = '0;
        end else if (((state_q == WAIT_START) || (state_q == RUN)) && (wdog_q != '1)) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant       <= '0;
            done        <= '0;
            seq_button  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            done        <= done_d;
            seq_button  <= button_d;
            busy        <= busy_d;
            timeout_err <= err_d;
            wdog_q      <= wdog_d;
        end
    end

endmodule

// File: tb/tb_rgb_seq_sched.sv
// Directed bench for rgb_seq_sched: a behavioural sequencer drives one instance,
// a second instance with TIMEOUT_MAX=8 and silent colours exercises the watchdog.
module tb_rgb_seq_sched;

    localparam int SEG = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] done;
    logic       seq_button;
    logic       seq_red   = 1'b0;
    logic       seq_green = 1'b0;
    logic       seq_blue  = 1'b0;
    logic       busy;
    logic       timeout_err;

    logic [3:0] wd_req;
    logic [3:0] wd_grant;
    logic [3:0] wd_done;
    logic       wd_button;
    logic       wd_zero = 1'b0;
    logic       wd_busy;
    logic       wd_timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_seq_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .done        (done),
        .seq_button  (seq_button),
        .seq_red     (seq_red),
        .seq_green   (seq_green),
        .seq_blue    (seq_blue),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    rgb_seq_sched #(.NUM_REQ(4), .TIMEOUT_MAX(8)) dut_wd (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (wd_req),
        .grant       (wd_grant),
        .done        (wd_done),
        .seq_button  (wd_button),
        .seq_red     (wd_zero),
        .seq_green   (wd_zero),
        .seq_blue    (wd_zero),
        .busy        (wd_busy),
        .timeout_err (wd_timeout_err)
    );

    // Sequencer model: button seen at an edge starts red on the next cycle, SEG cycles per colour.
    int   ph = 0;
    logic btn_s;
    always @(posedge clk) begin
        btn_s = seq_button;
        #1;
        if (!reset_n)                   ph = 0;
        else if (btn_s)                 ph = 1;
        else if (ph != 0 && ph < 3*SEG) ph = ph + 1;
        else                            ph = 0;
        seq_red   = (ph >= 1)         && (ph <= SEG);
        seq_green = (ph >= SEG + 1)   && (ph <= 2*SEG);
        seq_blue  = (ph >= 2*SEG + 1) && (ph <= 3*SEG);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick;
            if (grant != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick;
            if (done != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req     = 4'b0;
        wd_req  = 4'b0;
        tick;
        tick;
        checks++; if (grant !== 4'b0)     begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (done !== 4'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (seq_button !== 1'b0) begin errors++; $display("FAIL reset_button got=%b exp=0", seq_button); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
        checks++; if (wd_grant !== 4'b0)  begin errors++; $display("FAIL reset_wd_grant got=%b exp=0000", wd_grant); end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp [5];
        logic [3:0] g;
        bit         ok;
`ifdef RGB_SCHED_FIXED_PRIO_EN
        exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(100, ok);
            g = grant;
            checks++; if (!ok) begin errors++; $display("FAIL rr_grant_wait seq=%0d no grant within budget", k); end
            checks++; if (g !== exp[k]) begin errors++; $display("FAIL rr_grant seq=%0d got=%b exp=%b", k, g, exp[k]); end
            wait_done(100, ok);
            checks++; if (!ok || done !== exp[k]) begin errors++; $display("FAIL rr_done seq=%0d got=%b exp=%b", k, done, exp[k]); end
        end
        req = 4'b0;
        tick;
    endtask

    task automatic test_single;
        req = 4'b0001;
        tick;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t1_grant got=%b exp=0001", grant); end
        checks++; if (seq_button !== 1'b1) begin errors++; $display("FAIL t1_button_hi got=%b exp=1", seq_button); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL t1_busy got=%b exp=1", busy); end
        tick;
        checks++; if (seq_button !== 1'b0) begin errors++; $display("FAIL t1_button_lo got=%b exp=0", seq_button); end
        repeat (30) tick;
        checks++; if (done !== 4'b0)      begin errors++; $display("FAIL t1_done_early got=%b exp=0000", done); end
        tick;
        checks++; if (done !== 4'b0001)   begin errors++; $display("FAIL t1_done got=%b exp=0001", done); end
        req = 4'b0;
        tick;
        checks++; if (done !== 4'b0)      begin errors++; $display("FAIL t1_done_pulse got=%b exp=0000", done); end
        checks++; if (grant !== 4'b0)     begin errors++; $display("FAIL t1_grant_clr got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL t1_idle got=%b exp=0", busy); end
    endtask

    task automatic test_drop_req;
        bit ok;
        req = 4'b0100;
        tick;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL t4_grant got=%b exp=0100", grant); end
        repeat (4) tick;
        req[2] = 1'b0;
        repeat (5) tick;
        req[0] = 1'b1;
        repeat (10) tick;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL t4_grant_hold got=%b exp=0100", grant); end
        repeat (12) tick;
        checks++; if (done !== 4'b0)     begin errors++; $display("FAIL t4_done_early got=%b exp=0000", done); end
        tick;
        checks++; if (done !== 4'b0100)  begin errors++; $display("FAIL t4_done got=%b exp=0100", done); end
        tick;
        checks++; if (grant !== 4'b0)    begin errors++; $display("FAIL t4_idle_grant got=%b exp=0000", grant); end
        tick;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t4_pending_grant got=%b exp=0001", grant); end
        wait_done(100, ok);
        checks++; if (!ok || done !== 4'b0001) begin errors++; $display("FAIL t4_pending_done got=%b exp=0001", done); end
        req = 4'b0;
        tick;
    endtask

    task automatic test_timeout;
        bit ok;
        wd_req = 4'b0001;
        tick;
        checks++; if (wd_grant !== 4'b0001) begin errors++; $display("FAIL t3_grant got=%b exp=0001", wd_grant); end
        checks++; if (wd_button !== 1'b1)   begin errors++; $display("FAIL t3_button got=%b exp=1", wd_button); end
        repeat (8) tick;
        checks++; if (wd_done !== 4'b0)     begin errors++; $display("FAIL t3_done_early got=%b exp=0000", wd_done); end
        checks++; if (wd_timeout_err !== 1'b0) begin errors++; $display("FAIL t3_terr_early got=%b exp=0", wd_timeout_err); end
        tick;
        checks++; if (wd_done !== 4'b0001)  begin errors++; $display("FAIL t3_done got=%b exp=0001", wd_done); end
        checks++; if (wd_timeout_err !== 1'b1) begin errors++; $display("FAIL t3_terr got=%b exp=1", wd_timeout_err); end
        wd_req = 4'b0;
        tick;
        wd_req = 4'b0010;
        tick;
        checks++; if (wd_grant !== 4'b0010) begin errors++; $display("FAIL t3_next_grant got=%b exp=0010", wd_grant); end
        checks++; if (wd_timeout_err !== 1'b1) begin errors++; $display("FAIL t3_terr_sticky got=%b exp=1", wd_timeout_err); end
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick;
            if (wd_done != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok || wd_done !== 4'b0010) begin errors++; $display("FAIL t3_next_done got=%b exp=0010", wd_done); end
        wd_req = 4'b0;
        tick;
    endtask

    task automatic test_done_to_grant;
        bit ok;
        req = 4'b0001;
        wait_done(100, ok);
        checks++; if (!ok || done !== 4'b0001) begin errors++; $display("FAIL t6_done got=%b exp=0001", done); end
        req = 4'b0010;
        tick;
        checks++; if (grant !== 4'b0)    begin errors++; $display("FAIL t6_gap_grant got=%b exp=0000", grant); end
        tick;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t6_grant got=%b exp=0010", grant); end
        wait_done(100, ok);
        checks++; if (!ok || done !== 4'b0010) begin errors++; $display("FAIL t6_done2 got=%b exp=0010", done); end
        req = 4'b0;
        tick;
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        req = 4'b1000;
        tick;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL t5_grant got=%b exp=1000", grant); end
        repeat (7) tick;
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL t5_busy_run got=%b exp=1", busy); end
        reset_n = 1'b0;
        req     = 4'b0;
        #1;
        checks++; if (grant !== 4'b0)     begin errors++; $display("FAIL t5_rst_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL t5_rst_busy got=%b exp=0", busy); end
        checks++; if (seq_button !== 1'b0) begin errors++; $display("FAIL t5_rst_button got=%b exp=0", seq_button); end
        checks++; if (done !== 4'b0)      begin errors++; $display("FAIL t5_rst_done got=%b exp=0000", done); end
        checks++; if (wd_timeout_err !== 1'b0) begin errors++; $display("FAIL t5_rst_terr got=%b exp=0", wd_timeout_err); end
        tick;
        tick;
        checks++; if (done !== 4'b0)      begin errors++; $display("FAIL t5_rst_nodone got=%b exp=0000", done); end
        reset_n = 1'b1;
        req     = 4'b0100;
        tick;
        checks++; if (grant !== 4'b0100)  begin errors++; $display("FAIL t5_post_grant got=%b exp=0100", grant); end
        wait_done(100, ok);
        checks++; if (!ok || done !== 4'b0100) begin errors++; $display("FAIL t5_post_done got=%b exp=0100", done); end
        req = 4'b0;
        tick;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset;
        test_round_robin;
        test_single;
        test_drop_req;
        test_timeout;
        test_done_to_grant;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
